// File: rtl/tile_palette_engine_pkg.sv
// Shared types for the tile palette engine: fade FSM states and the packed
// {r,g,b} colour layout (red in the MSBs) used by palette entries.
package tile_palette_engine_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        FADE_OUT = 2'd2
    } fade_state_e;

    localparam int RGB_CH_W = 4;

    typedef struct packed {
        logic [RGB_CH_W-1:0] r;
        logic [RGB_CH_W-1:0] g;
        logic [RGB_CH_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/tile_palette_engine_fader.sv
// Brightness fader: FSM, step divider and brightness register. A fade_start
// pulse always (re)starts a fade from the current brightness.
module tile_palette_fader
    import tile_palette_engine_pkg::*;
#(
    parameter int CH_W     = 4,
    parameter int FADE_DIV = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fade_start,
    input  logic            fade_dir,
    output logic [CH_W-1:0] brightness,
    output logic            fade_busy,
    output logic            fade_done
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  B_MAX    = {CH_W{1'b1}};
    localparam logic [CH_W-1:0]  B_ZERO   = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  B_ONE    = {{(CH_W-1){1'b0}}, 1'b1};

    fade_state_e      state_r, state_s;
    logic [CH_W-1:0]  bright_r, bright_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic             done_r, done_s;
    logic             tick_s;

    // Next-state logic: a step fires on the last divider count; reaching (or
    // already sitting at) the endpoint on a step completes the fade.
    always_comb begin
        state_s  = state_r;
        bright_s = bright_r;
        div_s    = div_r;
        done_s   = 1'b0;
        tick_s   = (div_r == DIV_LAST);
        if (fade_start) begin
            state_s = fade_dir ? FADE_IN : FADE_OUT;
            div_s   = DIV_ZERO;
        end else begin
            case (state_r)
                FADE_IN: begin
                    if (tick_s) begin
                        div_s    = DIV_ZERO;
                        bright_s = (bright_r == B_MAX) ? bright_r : bright_r + B_ONE;
                        if (bright_s == B_MAX) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = FADE_IN;
                        end
                    end else begin
                        div_s = div_r + DIV_ONE;
                    end
                end
                FADE_OUT: begin
                    if (tick_s) begin
                        div_s    = DIV_ZERO;
                        bright_s = (bright_r == B_ZERO) ? bright_r : bright_r - B_ONE;
                        if (bright_s == B_ZERO) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = FADE_OUT;
                        end
                    end else begin
                        div_s = div_r + DIV_ONE;
                    end
                end
                IDLE: begin
                    div_s = DIV_ZERO;
                end
                default: begin
                    state_s = IDLE;
                    div_s   = DIV_ZERO;
                end
            endcase
        end
    end

    // State, brightness, divider and done-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            bright_r <= B_MAX;
            div_r    <= DIV_ZERO;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            bright_r <= bright_s;
            div_r    <= div_s;
            done_r   <= done_s;
        end
    end

    assign brightness = bright_r;
    assign fade_busy  = (state_r != IDLE);
    assign fade_done  = done_r;

endmodule

// File: rtl/tile_palette_engine.sv
// Banked palette lookup with a 2-stage datapath (read, then brightness scale)
// running alongside the fader; no stalls anywhere.
module tile_palette_engine
    import tile_palette_engine_pkg::*;
#(
    parameter int INDEX_W   = 5,
    parameter int NUM_BANKS = 4,
    parameter int CH_W      = 4,
    parameter int FADE_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pix_valid,
    input  logic [INDEX_W-1:0]           pix_index,
    input  logic [$clog2(NUM_BANKS)-1:0] pix_bank,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
    input  logic [INDEX_W-1:0]           wr_index,
    input  logic [3*CH_W-1:0]            wr_data,
    input  logic                         fade_start,
    input  logic                         fade_dir,
    output logic                         out_valid,
    output logic [CH_W-1:0]              red,
    output logic [CH_W-1:0]              green,
    output logic [CH_W-1:0]              blue,
    output logic [CH_W-1:0]              brightness,
    output logic                         fade_busy,
    output logic                         fade_done
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = NUM_BANKS << INDEX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int PROD_W = 2 * CH_W + 1;

    // (c * (b + 1)) >> CH_W keeps all-ones brightness lossless and zero dark.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                 input logic [CH_W-1:0] b);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * (PROD_W'(b) + {{(PROD_W-1){1'b0}}, 1'b1});
        return CH_W'(prod >> CH_W);
    endfunction

    logic [RGB_W-1:0]         mem_r [DEPTH];
    logic [RGB_W-1:0]         s1_rgb_r;
    logic                     s1_valid_r;
    logic                     out_valid_r;
    logic [CH_W-1:0]          red_r, green_r, blue_r;
    logic [CH_W-1:0]          bright_s;
    logic [BANK_W+INDEX_W-1:0] rd_addr_s, wr_addr_s;

    assign rd_addr_s = {pix_bank, pix_index};
    assign wr_addr_s = {wr_bank, wr_index};

    tile_palette_fader #(
        .CH_W     (CH_W),
        .FADE_DIV (FADE_DIV)
    ) u_fader (
        .clk        (clk),
        .reset_n    (reset_n),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .brightness (bright_s),
        .fade_busy  (fade_busy),
        .fade_done  (fade_done)
    );

    // Palette storage and stage 1; the non-blocking write makes a same-cycle
    // read of the written entry return the old contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {RGB_W{1'b0}};
            end
            s1_rgb_r   <= {RGB_W{1'b0}};
            s1_valid_r <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_r[wr_addr_s] <= wr_data;
            end
            if (pix_valid) begin
                s1_rgb_r <= mem_r[rd_addr_s];
            end
            s1_valid_r <= pix_valid;
        end
    end

    // Stage 2: brightness scaling; colour outputs hold between valid pixels.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            red_r       <= {CH_W{1'b0}};
            green_r     <= {CH_W{1'b0}};
            blue_r      <= {CH_W{1'b0}};
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                red_r   <= scale_ch(s1_rgb_r[3*CH_W-1:2*CH_W], bright_s);
                green_r <= scale_ch(s1_rgb_r[2*CH_W-1:CH_W],   bright_s);
                blue_r  <= scale_ch(s1_rgb_r[CH_W-1:0],        bright_s);
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;
    assign brightness = bright_s;

endmodule

// File: doc/tile_palette_engine.md
TILE_PALETTE_ENGINE -- requirements
Module: tile_palette_engine

Interface
REQ-001 Parameter INDEX_W, default 5, palette index width (entries per bank = 2^INDEX_W).
REQ-002 Parameter NUM_BANKS, default 4, number of independent palette banks (power of two, >= 2).
REQ-003 Parameter CH_W, default 4, bits per colour channel.
REQ-004 Parameter FADE_DIV, default 4, clock cycles per brightness step (>= 1).
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  synchronous active-low reset.
REQ-007 pix_valid  input  1  lookup request this cycle.
REQ-008 pix_index  input  INDEX_W  palette entry to look up.
REQ-009 pix_bank  input  log2(NUM_BANKS)  bank to look up.
REQ-010 wr_en  input  1  palette write strobe.
REQ-011 wr_bank  input  log2(NUM_BANKS)  bank to write.
REQ-012 wr_index  input  INDEX_W  entry to write.
REQ-013 wr_data  input  3*CH_W  {red, green, blue}, red in MSBs.
REQ-014 fade_start  input  1  one-cycle pulse starting a fade.
REQ-015 fade_dir  input  1  sampled with fade_start; 1 = fade in (to max), 0 = fade out (to 0).
REQ-016 out_valid  output  1  red/green/blue valid this cycle.
REQ-017 red, green, blue  output  CH_W each  scaled colour.
REQ-018 brightness  output  CH_W  current brightness level.
REQ-019 fade_busy  output  1  high while state is not IDLE.
REQ-020 fade_done  output  1  one-cycle pulse on fade completion.

Function
REQ-021 Storage: NUM_BANKS x 2^INDEX_W entries of 3*CH_W bits, one write port, one read port.
REQ-022 wr_en high writes wr_data to [wr_bank][wr_index] at the clock edge.
REQ-023 Stage 1: on pix_valid, entry [pix_bank][pix_index] registered; same-cycle write to the same entry returns old data (read-before-write).
REQ-024 Stage 2: each channel c registered as (c * (brightness + 1)) >> CH_W, computed at (2*CH_W+1) bits, truncated to CH_W; brightness sampled when the pixel is in stage 2.
REQ-025 out_valid equals pix_valid delayed exactly 2 cycles; red/green/blue hold last value when out_valid low.
REQ-026 brightness all-ones yields out == stored colour exactly; brightness 0 yields 0 for every channel.
REQ-027 FSM states IDLE, FADE_IN, FADE_OUT; fade_start with fade_dir=1 -> FADE_IN, fade_dir=0 -> FADE_OUT, from any state.
REQ-028 Divider counter clears on fade_start; in FADE_IN/FADE_OUT brightness steps +1/-1 every FADE_DIV cycles.
REQ-029 Reaching all-ones in FADE_IN or 0 in FADE_OUT: transition to IDLE, fade_done high for that one cycle.
REQ-030 fade_start while already at the target endpoint: enter the fade state, then IDLE with fade_done after FADE_DIV cycles, brightness unchanged.
REQ-031 fade_start mid-fade: direction reversed/restarted from current brightness, no fade_done for the aborted fade.
REQ-032 Lookup, write and fade operate concurrently without stalls; no backpressure.

Reset
REQ-033 Reset_n low at a clock edge: state IDLE, brightness all-ones, divider 0, out_valid 0, red/green/blue 0, fade_done 0, pipeline valid bits 0.
REQ-034 Reset clears every palette entry to 0; reset mid-fade aborts with no fade_done.
REQ-035 Inputs ignored during reset cycles, including wr_en.

Structure
REQ-036 Shared package holds the fade state enum and an rgb typedef parametrised by CH_W usage ({r,g,b} packing).
REQ-037 One sub-module, tile_palette_fader, holds the FSM, divider and brightness register; the top holds storage and the 2-stage datapath.

Verification
REQ-038 Write bank 2 index 7 = 12'hA5C, lookup bank 2 index 7 -> 2 cycles later out_valid=1, {r,g,b}={A,5,C}.
REQ-039 Same-cycle write 12'hFFF and read of an entry holding 12'h123 -> output 12'h123; next read -> 12'hFFF.
REQ-040 FADE_DIV=4, fade_start dir=0 from 15 -> brightness 0 after 60 cycles, fade_done pulse once, fade_busy low next; entry 12'hFFF reads 12'h000.
REQ-041 Brightness 7, entry 12'hF84 -> output {7,4,2}.
REQ-042 Fade out to 10, fade_start dir=1 -> counts up from 10 to 15, single fade_done.
REQ-043 Reset_n low mid-fade with pixels in flight -> next cycle out_valid=0, brightness=15, fade_busy=0, all entries read 0.
